// File: rtl/srdax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srdax_pkg
// Description : Shared definitions for the SRDAX frame path. Holds the
//               frame verdict command encoding (also used by the transmit
//               side FIFO command driver) and the receive write FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package srdax_pkg;

  // Frame verdict commands. Encoding 3 is reserved and treated as NONE.
  localparam logic [1:0] FRAME_CMD_NONE    = 2'd0;
  localparam logic [1:0] FRAME_CMD_COMMIT  = 2'd1;
  localparam logic [1:0] FRAME_CMD_DISCARD = 2'd2;

  // Receive write-side FSM.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FRAME = 2'd1,
    WR_OVF   = 2'd2
  } wr_state_e;

  // True for a command that ends the current frame (commit or discard).
  function automatic logic is_verdict(input logic [1:0] cmd);
    return (cmd == FRAME_CMD_COMMIT) || (cmd == FRAME_CMD_DISCARD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/srdax_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : srdax_axis_out_reg
// Description : Single-entry AXI-Stream output register. Loads a word when
//               told to, holds it stable under backpressure and drops valid
//               only on a handshake without a new load.
// Ports       : clk_slow, reset (sync, active-low)
//               load_i        - capture data_i/last_i this cycle
//               data_i/last_i - word presented by the storage array
//               tready_i      - downstream ready
//               tvalid_o/tdata_o/tlast_o - registered stream outputs
//               can_load_o    - register is free or being emptied this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module srdax_axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_slow,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  tready_i,
  output logic                  tvalid_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tlast_o,
  output logic                  can_load_o
);

  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;

  assign can_load_o = !tvalid_q || tready_i;

  always_ff @(posedge clk_slow) begin
    if (!reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= data_i;
      tlast_q  <= last_i;
    end else if (tvalid_q && tready_i) begin
      // Data is left in place; only valid drops after the final handshake.
      tvalid_q <= 1'b0;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign tlast_o  = tlast_q;

endmodule
`default_nettype wire

// File: rtl/srdax_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : srdax_frame_fifo
// Description : Receive frame buffer between the SERDES deserializer and the
//               AXI side. Words are written speculatively; a CRC verdict
//               either commits the frame or rolls the write pointer back, so
//               only good frames are ever streamed out.
// Ports       : clk_slow, reset (sync, active-low)
//               wr_en_i/wr_data_i/wr_last_i - deserializer word input
//               frame_cmd_i                 - 0 none, 1 commit, 2 discard
//               m_axis_*                    - AXI-Stream master
//               fifo_full_o  - storage holds FIFO_DEPTH entries
//               fifo_empty_o - nothing committed and output register idle
//               overflow_o   - current frame lost a word
//               drop_cnt_o   - saturating discarded-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module srdax_frame_fifo
  import srdax_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_slow,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic [1:0]            frame_cmd_i,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

  wr_state_e        state_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_first_q, wr_ptr_first_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
  logic [CNT_W-1:0] comm_cnt_q, comm_cnt_d;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;

  logic             full;
  logic             wr_acc;
  logic             wr_lost;
  logic             verdict;
  logic             do_commit;
  logic             do_discard;
  logic             drop_frame;
  logic             can_load;
  logic             load;
  logic [CNT_W-1:0] commit_amt;
  logic             out_tvalid;

  assign full = ({1'b0, spec_cnt_q} + {1'b0, comm_cnt_q}) == (CNT_W + 1)'(FIFO_DEPTH);

  assign wr_acc  = wr_en_i && !full && (state_q != WR_OVF);
  // A word that arrives while full costs the frame its integrity.
  assign wr_lost = wr_en_i && full && (state_q != WR_OVF);
  assign verdict = is_verdict(frame_cmd_i);

  // A frame that lost a word can never be committed; any verdict discards it.
  assign do_commit  = (frame_cmd_i == FRAME_CMD_COMMIT) && (state_q != WR_OVF) && !wr_lost;
  assign do_discard = verdict && !do_commit;
  assign drop_frame = do_discard &&
                      ((spec_cnt_q != '0) || wr_acc || wr_lost || (state_q == WR_OVF));

  assign commit_amt = do_commit ? (spec_cnt_q + CNT_W'(wr_acc)) : '0;
  assign load       = (comm_cnt_q != '0) && can_load;

  // Storage write. The slot at wr_ptr is always free when a write is accepted.
  always_ff @(posedge clk_slow) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {wr_last_i, wr_data_i};
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    wr_ptr_first_d = wr_ptr_first_q;
    rd_ptr_d       = rd_ptr_q;
    spec_cnt_d     = spec_cnt_q;

    if (wr_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (do_commit) begin
      // Post-write pointer, so a same-cycle word joins the committed frame.
      wr_ptr_first_d = wr_ptr_d;
      spec_cnt_d     = '0;
    end else if (do_discard) begin
      // Rollback also drops any word written this cycle.
      wr_ptr_d   = wr_ptr_first_q;
      spec_cnt_d = '0;
    end else if (wr_acc) begin
      spec_cnt_d = spec_cnt_q + 1'b1;
    end

    if (load) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    comm_cnt_d = comm_cnt_q + commit_amt - CNT_W'(load);
  end

  always_ff @(posedge clk_slow) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      wr_ptr_first_q <= '0;
      rd_ptr_q       <= '0;
      spec_cnt_q     <= '0;
      comm_cnt_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      wr_ptr_first_q <= wr_ptr_first_d;
      rd_ptr_q       <= rd_ptr_d;
      spec_cnt_q     <= spec_cnt_d;
      comm_cnt_q     <= comm_cnt_d;
    end
  end

  // Write FSM with its registered outputs.
  always_ff @(posedge clk_slow) begin
    if (!reset) begin
      state_q    <= WR_IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (verdict) begin
      state_q    <= WR_IDLE;
      overflow_q <= 1'b0;
      if (drop_frame && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        // A frame whose first word already finds storage full is lost too.
        WR_IDLE: begin
          if (wr_lost) begin
            state_q <= WR_OVF;
          end else if (wr_acc) begin
            state_q <= WR_FRAME;
          end
        end
        WR_FRAME: begin
          if (wr_lost) begin
            state_q <= WR_OVF;
          end
        end
        WR_OVF:  state_q <= WR_OVF;
        default: state_q <= WR_IDLE;
      endcase
      if (wr_lost) begin
        overflow_q <= 1'b1;
      end
    end
  end

  srdax_axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_axis_out (
    .clk_slow   (clk_slow),
    .reset      (reset),
    .load_i     (load),
    .data_i     (mem_q[rd_ptr_q][DATA_WIDTH-1:0]),
    .last_i     (mem_q[rd_ptr_q][DATA_WIDTH]),
    .tready_i   (m_axis_tready),
    .tvalid_o   (out_tvalid),
    .tdata_o    (m_axis_tdata),
    .tlast_o    (m_axis_tlast),
    .can_load_o (can_load)
  );

  assign m_axis_tvalid = out_tvalid;
  assign fifo_full_o   = full;
  assign fifo_empty_o  = (comm_cnt_q == '0) && !out_tvalid;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_srdax_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_srdax_frame_fifo
// Description : Directed self-checking bench for srdax_frame_fifo. Expected
//               beats are queued by the stimulus and compared by a stream
//               monitor; flags and counters are checked at fixed cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srdax_frame_fifo;
  import srdax_pkg::*;

  localparam int DW = 32;

  logic          clk_slow = 1'b0;
  logic          reset;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_last_i;
  logic [1:0]    frame_cmd_i;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          fifo_full_o;
  logic          fifo_empty_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_beats  = 0;
  int            n_lasts  = 0;
  bit            rand_rdy = 1'b0;
  logic [DW:0]   exp_q[$];

  always #5 clk_slow = ~clk_slow;

  srdax_frame_fifo #(
    .FIFO_DEPTH (16),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_slow      (clk_slow),
    .reset         (reset),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .wr_last_i     (wr_last_i),
    .frame_cmd_i   (frame_cmd_i),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_full_o   (fifo_full_o),
    .fifo_empty_o  (fifo_empty_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1ns after the edge.
  task automatic tick();
    @(posedge clk_slow);
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic l, input logic [1:0] cmd,
                         input bit wait_room);
    int n = 0;
    if (wait_room) begin
      while (fifo_full_o && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) chk("room_wait_timeout", 64'(n), 64'd0);
    end
    wr_en_i     = 1'b1;
    wr_data_i   = d;
    wr_last_i   = l;
    frame_cmd_i = cmd;
    tick();
    wr_en_i     = 1'b0;
    wr_last_i   = 1'b0;
    frame_cmd_i = FRAME_CMD_NONE;
  endtask

  task automatic cmd_only(input logic [1:0] cmd);
    frame_cmd_i = cmd;
    tick();
    frame_cmd_i = FRAME_CMD_NONE;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !fifo_empty_o) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    chk({tag, "_empty"}, 64'(fifo_empty_o), 64'd1);
  endtask

  // Stream monitor: scoreboard compare plus hold-under-stall check.
  bit          stall_prev = 1'b0;
  logic [DW:0] held;
  always @(negedge clk_slow) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(held));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        if (m_axis_tlast) n_lasts++;
        if (exp_q.size() == 0) chk("extra_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'h1_dead_beef_0);
        else chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    bit seen_v, seen_f;
    int b0, l0;
    reset         = 1'b0;
    wr_en_i       = 1'b0;
    wr_data_i     = '0;
    wr_last_i     = 1'b0;
    frame_cmd_i   = FRAME_CMD_NONE;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // ---- reset values
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_full", 64'(fifo_full_o), 64'd0);
    chk("rst_empty", 64'(fifo_empty_o), 64'd1);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);

    // ---- good frame: commit latency and consecutive beats
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), 32'hA0 + 32'(i)});
      wr_word(32'hA0 + 32'(i), (i == 3), FRAME_CMD_NONE, 1'b0);
    end
    chk("pre_commit_empty", 64'(fifo_empty_o), 64'd1);
    cmd_only(FRAME_CMD_COMMIT);
    chk("commit_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("commit_n1_empty", 64'(fifo_empty_o), 64'd0);
    tick();
    chk("commit_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("commit_n2_tdata", 64'(m_axis_tdata), 64'hA0);
    tick();
    chk("b2b_a1", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), {31'd0, 1'b1, 1'b0, 32'hA1});
    tick();
    chk("b2b_a2", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), {31'd0, 1'b1, 1'b0, 32'hA2});
    tick();
    chk("b2b_a3", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), {31'd0, 1'b1, 1'b1, 32'hA3});
    tick();
    chk("good_done_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("good_done_empty", 64'(fifo_empty_o), 64'd1);

    // ---- bad frame never reaches the stream
    for (int i = 0; i < 3; i++) wr_word(32'hB0 + 32'(i), (i == 2), FRAME_CMD_NONE, 1'b0);
    cmd_only(FRAME_CMD_DISCARD);
    seen_v = 1'b0;
    seen_f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_axis_tvalid) seen_v = 1'b1;
      if (fifo_full_o) seen_f = 1'b1;
      tick();
    end
    chk("bad_no_tvalid", 64'(seen_v), 64'd0);
    chk("bad_no_full", 64'(seen_f), 64'd0);
    chk("bad_drop_cnt", 64'(drop_cnt_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), 32'hC0 + 32'(i)});
      wr_word(32'hC0 + 32'(i), (i == 3), FRAME_CMD_NONE, 1'b0);
    end
    cmd_only(FRAME_CMD_COMMIT);
    drain("after_bad_drain");

    // ---- overflow: 20 words into 16 entries, then a commit attempt
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_word(32'hD00 + 32'(i), (i == 19), FRAME_CMD_NONE, 1'b0);
      if (i == 14) chk("ovf_not_full_15", 64'(fifo_full_o), 64'd0);
      if (i == 15) begin
        chk("ovf_full_16", 64'(fifo_full_o), 64'd1);
        chk("ovf_flag_16", 64'(overflow_o), 64'd0);
      end
      if (i == 16) chk("ovf_flag_17", 64'(overflow_o), 64'd1);
    end
    cmd_only(FRAME_CMD_COMMIT);
    chk("ovf_drop_cnt", 64'(drop_cnt_o), 64'd2);
    chk("ovf_cleared", 64'(overflow_o), 64'd0);
    chk("ovf_full_clear", 64'(fifo_full_o), 64'd0);
    repeat (5) tick();
    chk("ovf_empty_stays", 64'({m_axis_tvalid, fifo_empty_o}), 64'b01);
    m_axis_tready = 1'b1;
    // A full 16-word frame must fit again, proving nothing speculative remains.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i == 15), 32'hE00 + 32'(i)});
      wr_word(32'hE00 + 32'(i), (i == 15), FRAME_CMD_NONE, 1'b0);
    end
    chk("post_ovf_no_flag", 64'(overflow_o), 64'd0);
    cmd_only(FRAME_CMD_COMMIT);
    drain("post_ovf_drain");

    // ---- three 7-word frames under random backpressure, across the wrap
    b0 = n_beats;
    l0 = n_lasts;
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 7; i++) begin
        exp_q.push_back({(i == 6), 32'h500 + 32'(f * 16 + i)});
        wr_word(32'h500 + 32'(f * 16 + i), (i == 6), FRAME_CMD_NONE, 1'b1);
      end
      cmd_only(FRAME_CMD_COMMIT);
    end
    rand_rdy = 1'b0;
    m_axis_tready = 1'b1;
    drain("wrap_drain");
    chk("wrap_beats", 64'(n_beats - b0), 64'd21);
    chk("wrap_lasts", 64'(n_lasts - l0), 64'd3);

    // ---- simultaneous write + commit + load
    b0 = n_beats;
    exp_q.push_back({1'b0, 32'h600});
    exp_q.push_back({1'b1, 32'h601});
    exp_q.push_back({1'b0, 32'h610});
    exp_q.push_back({1'b1, 32'h611});
    wr_word(32'h600, 1'b0, FRAME_CMD_NONE, 1'b0);
    wr_word(32'h601, 1'b1, FRAME_CMD_NONE, 1'b0);
    cmd_only(FRAME_CMD_COMMIT);
    wr_word(32'h610, 1'b0, FRAME_CMD_NONE, 1'b0);
    chk("sim_commit_loading", 64'(m_axis_tvalid), 64'd1);
    wr_word(32'h611, 1'b1, FRAME_CMD_COMMIT, 1'b0);
    drain("sim_commit_drain");
    chk("sim_commit_beats", 64'(n_beats - b0), 64'd4);

    // ---- simultaneous write + discard + load
    b0 = n_beats;
    exp_q.push_back({1'b0, 32'h700});
    exp_q.push_back({1'b1, 32'h701});
    exp_q.push_back({1'b1, 32'h720});
    wr_word(32'h700, 1'b0, FRAME_CMD_NONE, 1'b0);
    wr_word(32'h701, 1'b1, FRAME_CMD_NONE, 1'b0);
    cmd_only(FRAME_CMD_COMMIT);
    wr_word(32'h710, 1'b0, FRAME_CMD_NONE, 1'b0);
    wr_word(32'h711, 1'b1, FRAME_CMD_DISCARD, 1'b0);
    chk("sim_disc_drop_cnt", 64'(drop_cnt_o), 64'd3);
    wr_word(32'h720, 1'b1, FRAME_CMD_COMMIT, 1'b0);
    drain("sim_disc_drain");
    chk("sim_disc_beats", 64'(n_beats - b0), 64'd3);

    // ---- reset mid-stream with a stalled beat
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) wr_word(32'h800 + 32'(i), (i == 3), FRAME_CMD_NONE, 1'b0);
    cmd_only(FRAME_CMD_COMMIT);
    tick();
    tick();
    chk("pre_rst_stalled", 64'(m_axis_tvalid), 64'd1);
    reset = 1'b0;
    tick();
    chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("rst_mid_state", 64'({m_axis_tvalid, fifo_empty_o, fifo_full_o}), 64'b010);
    chk("rst_mid_drop", 64'(drop_cnt_o), 64'd0);
    m_axis_tready = 1'b1;
    b0 = n_beats;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({(i == 2), 32'h900 + 32'(i)});
      wr_word(32'h900 + 32'(i), (i == 2), FRAME_CMD_NONE, 1'b0);
    end
    cmd_only(FRAME_CMD_COMMIT);
    drain("post_rst_drain");
    chk("post_rst_beats", 64'(n_beats - b0), 64'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
